dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: the CPU load/store port and the video fetch port, which reads sprite and pipe data for the display.
- Decodes CPU addresses: region addr[31:28]==0 goes to data RAM; all other regions go to a memory-mapped IO write strobe.
- Applies fixed CPU priority with a starvation guard for video.
- Returns read data with the synchronous RAM's one-cycle latency.

---
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data RAM: the CPU load/store port has priority,
// and the video fetch port gets a forced win after MAX_WAIT consecutive denials.
module dmem_arbiter #(
    parameter int AW       = 11,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [31:0]   c_addr,
    input  logic [31:0]   c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [31:0]   c_rdata,
    input  logic          v_req,
    input  logic [31:0]   v_addr,
    output logic          v_gnt,
    output logic          v_rvalid,
    output logic [31:0]   v_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          io_we,
    output logic [31:0]   io_addr,
    output logic [31:0]   io_wdata
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic       c_ram;
    logic       c_ram_req;
    logic       c_io_req;
    logic       v_ram_req;
    logic       force_video;
    logic       c_win;
    logic       v_win;
    logic [3:0] wait_cnt_reg;
    logic [3:0] wait_cnt_next;
    logic       c_rvalid_reg;
    logic       c_region_reg;
    logic       v_rvalid_reg;

    // Address bits above the RAM word index alias silently and are not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{c_addr[27:AW+2], c_addr[1:0], v_addr[31:AW+2], v_addr[1:0]};

    always_comb begin
        c_ram       = (c_addr[31:28] == 4'b0);
        c_ram_req   = c_req & c_ram & ~rst;
        c_io_req    = c_req & ~c_ram & ~rst;
        v_ram_req   = v_req & ~rst;
        force_video = (wait_cnt_reg == WAIT_LIMIT);

        c_win = c_ram_req & (~v_ram_req | ~force_video);
        v_win = v_ram_req & (~c_ram_req | force_video);

        c_gnt = c_io_req | c_win;
        v_gnt = v_win;

        mem_en    = c_win | v_win;
        mem_we    = c_win & c_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (c_win) begin
            mem_addr  = c_addr[AW+1:2];
            mem_wdata = c_wdata;
        end else if (v_win) begin
            mem_addr  = v_addr[AW+1:2];
        end

        // MMIO side never contends with video, so it is granted independently.
        io_we    = c_io_req & c_we;
        io_addr  = rst ? 32'h0 : c_addr;
        io_wdata = rst ? 32'h0 : c_wdata;
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (v_gnt || !v_req) begin
            wait_cnt_next = 4'h0;
        end else if (wait_cnt_reg != WAIT_LIMIT) begin
            wait_cnt_next = wait_cnt_reg + 4'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= 4'h0;
            c_rvalid_reg <= 1'b0;
            c_region_reg <= 1'b0;
            v_rvalid_reg <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            c_rvalid_reg <= c_gnt & ~c_we;
            c_region_reg <= c_ram;
            v_rvalid_reg <= v_gnt;
        end
    end

    // IO reads complete with zero data; RAM reads see the word one cycle after the grant.
    assign c_rvalid = c_rvalid_reg;
    assign c_rdata  = (c_rvalid_reg & c_region_reg) ? mem_rdata : 32'h0;
    assign v_rvalid = v_rvalid_reg;
    assign v_rdata  = v_rvalid_reg ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table plus hand sequences, with a read-data scoreboard
// fed from a shadow copy of the RAM contents the bench itself has written.
module tb_dmem_arbiter;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, c_we, v_req;
    logic [31:0]   c_addr, c_wdata, v_addr;
    logic          c_gnt, c_rvalid, v_gnt, v_rvalid;
    logic [31:0]   c_rdata, v_rdata;
    logic          mem_en, mem_we, io_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata, io_addr, io_wdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .v_req(v_req), .v_addr(v_addr), .v_gnt(v_gnt),
        .v_rvalid(v_rvalid), .v_rdata(v_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata)
    );

    // Synchronous single-port RAM the arbiter drives.
    logic [31:0] ram [0:(1<<AW)-1];
    logic [31:0] ram_q;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    typedef struct {
        logic          rst;
        logic          c_req, c_we;
        logic [31:0]   c_addr, c_wdata;
        logic          v_req;
        logic [31:0]   v_addr;
        logic          e_cg, e_vg, e_en, e_we;
        logic [AW-1:0] e_addr;
        logic          e_iowe;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;
    logic [31:0] shadow [0:(1<<AW)-1];
    logic [31:0] cq[$];
    logic [31:0] vq[$];
    vec_t tbl[13];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL txn=%0d %s actual=%h required=%h", txn, name, act, req);
        end
    endfunction

    function automatic vec_t mk(logic r, logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
                                logic vr, logic [31:0] va, logic gc, logic gv, logic en,
                                logic we, logic [AW-1:0] ea, logic iow);
        vec_t v;
        v.rst = r; v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
        v.v_req = vr; v.v_addr = va; v.e_cg = gc; v.e_vg = gv; v.e_en = en;
        v.e_we = we; v.e_addr = ea; v.e_iowe = iow;
        return v;
    endfunction

    task automatic step(input vec_t v);
        logic [31:0] exp_d;
        @(negedge clk);
        // Read returns from the previous cycle's grants.
        if (v.rst) begin
            cq.delete();
            vq.delete();
        end else begin
            if (cq.size() > 0) begin
                exp_d = cq.pop_front();
                chk("c_rvalid", 32'(c_rvalid), 32'd1);
                chk("c_rdata", c_rdata, exp_d);
            end else begin
                chk("c_rvalid", 32'(c_rvalid), 32'd0);
                chk("c_rdata_idle", c_rdata, 32'h0);
            end
            if (vq.size() > 0) begin
                exp_d = vq.pop_front();
                chk("v_rvalid", 32'(v_rvalid), 32'd1);
                chk("v_rdata", v_rdata, exp_d);
            end else begin
                chk("v_rvalid", 32'(v_rvalid), 32'd0);
                chk("v_rdata_idle", v_rdata, 32'h0);
            end
        end
        rst = v.rst; c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr;
        c_wdata = v.c_wdata; v_req = v.v_req; v_addr = v.v_addr;
        #1;
        chk("c_gnt", 32'(c_gnt), 32'(v.e_cg));
        chk("v_gnt", 32'(v_gnt), 32'(v.e_vg));
        chk("mem_en", 32'(mem_en), 32'(v.e_en));
        chk("mem_we", 32'(mem_we), 32'(v.e_we));
        chk("mem_addr", 32'(mem_addr), 32'(v.e_addr));
        chk("mem_wdata", mem_wdata, v.e_we ? v.c_wdata : 32'h0);
        chk("io_we", 32'(io_we), 32'(v.e_iowe));
        chk("io_addr", io_addr, v.rst ? 32'h0 : v.c_addr);
        chk("io_wdata", io_wdata, v.rst ? 32'h0 : v.c_wdata);
        $display("txn %0d rst=%0b c_req=%0b c_we=%0b c_addr=%h v_req=%0b v_addr=%h -> c_gnt=%0b v_gnt=%0b mem_en=%0b mem_addr=%0d io_we=%0b",
                 txn, v.rst, v.c_req, v.c_we, v.c_addr, v.v_req, v.v_addr,
                 c_gnt, v_gnt, mem_en, mem_addr, io_we);
        // Scoreboard: expectations come from the bench's own shadow memory.
        if (!v.rst) begin
            if (v.e_cg && !v.c_we)
                cq.push_back((v.c_addr[31:28] == 4'h0) ? shadow[v.c_addr[AW+1:2]] : 32'h0);
            if (v.e_vg)
                vq.push_back(shadow[v.v_addr[AW+1:2]]);
            if (v.e_cg && v.c_we && v.c_addr[31:28] == 4'h0)
                shadow[v.c_addr[AW+1:2]] = v.c_wdata;
        end
        txn++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic g;
        rst = 1'b1; c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        v_req = 1'b0; v_addr = '0;

        tbl[0]  = mk(1, 1, 0, 32'h10,        32'h0,        1, 32'h20,        0, 0, 0, 0, 11'd0, 0);
        tbl[1]  = mk(1, 1, 1, 32'h1000_0000, 32'h9,        1, 32'h20,        0, 0, 0, 0, 11'd0, 0);
        tbl[2]  = mk(0, 1, 1, 32'h10,        32'hDEADBEEF, 0, 32'h0,         1, 0, 1, 1, 11'd4, 0);
        tbl[3]  = mk(0, 1, 1, 32'h20,        32'hCAFEF00D, 0, 32'h0,         1, 0, 1, 1, 11'd8, 0);
        tbl[4]  = mk(0, 1, 0, 32'h10,        32'h0,        0, 32'h0,         1, 0, 1, 0, 11'd4, 0);
        tbl[5]  = mk(0, 0, 0, 32'h0,         32'h0,        0, 32'h0,         0, 0, 0, 0, 11'd0, 0);
        tbl[6]  = mk(0, 1, 1, 32'h1000_0004, 32'h5,        0, 32'h0,         1, 0, 0, 0, 11'd0, 1);
        tbl[7]  = mk(0, 1, 0, 32'h2000_0000, 32'h0,        0, 32'h0,         1, 0, 0, 0, 11'd0, 0);
        tbl[8]  = mk(0, 1, 1, 32'h1000_0008, 32'h77,       1, 32'h20,        1, 1, 1, 0, 11'd8, 1);
        tbl[9]  = mk(0, 1, 0, 32'h0000_2010, 32'h0,        0, 32'h0,         1, 0, 1, 0, 11'd4, 0);
        tbl[10] = mk(0, 0, 0, 32'h0,         32'h0,        1, 32'hF000_0010, 0, 1, 1, 0, 11'd4, 0);
        tbl[11] = mk(0, 1, 1, 32'h24,        32'h1111_1111, 1, 32'h20,       1, 0, 1, 1, 11'd9, 0);
        tbl[12] = mk(0, 0, 0, 32'h0,         32'h0,        0, 32'h0,         0, 0, 0, 0, 11'd0, 0);

        for (int i = 0; i < 13; i++) step(tbl[i]);

        // Fill eight words, then stream them back through the video port.
        for (int i = 0; i < 8; i++)
            step(mk(0, 1, 1, 32'h40 + 32'(4*i), 32'hA000_0000 + 32'(i), 0, 32'h0,
                    1, 0, 1, 1, 11'(16+i), 0));
        for (int i = 0; i < 8; i++)
            step(mk(0, 0, 0, 32'h0, 32'h0, 1, 32'h40 + 32'(4*i),
                    0, 1, 1, 0, 11'(16+i), 0));
        step(tbl[12]);

        // Both held: CPU wins four cycles, video forced on the fifth.
        for (int i = 0; i < 10; i++) begin
            g = ((i % 5) != 4);
            step(mk(0, 1, 0, 32'h10, 32'h0, 1, 32'h20, g, !g, 1, 0, g ? 11'd4 : 11'd8, 0));
        end
        step(tbl[12]);

        // Reset after a CPU read grant with video already waiting.
        step(mk(0, 1, 0, 32'h10, 32'h0, 1, 32'h20, 1, 0, 1, 0, 11'd4, 0));
        step(mk(1, 1, 0, 32'h10, 32'h0, 1, 32'h20, 0, 0, 0, 0, 11'd0, 0));
        for (int i = 0; i < 5; i++) begin
            g = (i != 4);
            step(mk(0, 1, 0, 32'h10, 32'h0, 1, 32'h20, g, !g, 1, 0, g ? 11'd4 : 11'd8, 0));
        end
        step(tbl[12]);
        step(tbl[12]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
